// File: rtl/hilo_pkg.sv
// hilo_pkg: shared definitions for the HI/LO register pair and its
// speculative write queue.
//   RD_SEL_LO / RD_SEL_HI : encodings of the rd_sel read-lane select
//   LANE_HI / LANE_LO     : bit positions of the lane enables in wen
//   hilo_entry_t          : one queue entry {wen, hi, lo} at the default width
package hilo_pkg;

  localparam int HILO_DW = 32;

  localparam logic [1:0] RD_SEL_LO = 2'b01;
  localparam logic [1:0] RD_SEL_HI = 2'b10;

  localparam int LANE_HI = 1;
  localparam int LANE_LO = 0;

  typedef struct packed {
    logic [1:0]         wen;
    logic [HILO_DW-1:0] hi;
    logic [HILO_DW-1:0] lo;
  } hilo_entry_t;

endpackage

// File: rtl/hilo_fwd.sv
// hilo_fwd: combinational youngest-match search for one lane of the
// HI/LO write queue. Returns the data of the youngest valid entry whose
// enable for this lane is set, or the architectural value when none is.
//   lane_wen  : per-entry enable bit for this lane
//   lane_data : per-entry data for this lane
//   rp        : read pointer (oldest valid entry)
//   count     : number of valid entries starting at rp
//   arch      : committed architectural value of this lane
//   rdata     : forwarded value
module hilo_fwd
  import hilo_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic [DEPTH-1:0]         lane_wen,
  input  logic [DEPTH-1:0][DW-1:0] lane_data,
  input  logic [$clog2(DEPTH)-1:0] rp,
  input  logic [CW-1:0]            count,
  input  logic [DW-1:0]            arch,
  output logic [DW-1:0]            rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] idx;

  // Walk from oldest to youngest; a later match overrides an earlier one,
  // so the final value is the youngest entry that writes this lane.
  // The AW-bit add wraps modulo DEPTH because DEPTH is a power of two.
  always_comb begin
    rdata = arch;
    idx   = rp;
    for (int k = 0; k < DEPTH; k++) begin
      idx = rp + AW'(k);
      if ((CW'(k) < count) && lane_wen[idx]) begin
        rdata = lane_data[idx];
      end
    end
  end

endmodule

// File: rtl/hilo_queue.sv
// hilo_queue: HI/LO architectural register pair fronted by an in-order
// speculative write queue. Execute enqueues mul/div/MTHI/MTLO results,
// commit retires the oldest entry into HI/LO, flush discards everything
// not retired this cycle. Reads forward the youngest in-flight value.
//   clk, resetn        : clock, asynchronous active-low reset
//   wr_valid/wr_ready  : enqueue handshake (wr_ready = !full)
//   wr_en, wr_hi, wr_lo: entry lane enables {HI,LO} and data
//   commit, flush      : retire oldest / discard remaining entries
//   rd_sel, rdata      : forwarded read (01 = LO, anything else = HI)
//   hi_q, lo_q         : committed HI and LO
//   count, empty, full : queue occupancy
//   err                : sticky commit-while-empty flag
module hilo_queue
  import hilo_pkg::*;
#(
  parameter int DW    = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [1:0]    wr_en,
  input  logic [DW-1:0] wr_hi,
  input  logic [DW-1:0] wr_lo,
  input  logic          commit,
  input  logic          flush,
  input  logic [1:0]    rd_sel,
  output logic [DW-1:0] rdata,
  output logic [DW-1:0] hi_q,
  output logic [DW-1:0] lo_q,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          err
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][DW-1:0] hi_mem;
  logic [DEPTH-1:0][DW-1:0] lo_mem;
  logic [DEPTH-1:0]         wen_hi_mem;
  logic [DEPTH-1:0]         wen_lo_mem;

  logic [AW-1:0] rp;
  logic [AW-1:0] wp;
  logic [AW-1:0] rp_next;
  logic          do_enq;
  logic          do_commit;
  logic [DW-1:0] fwd_hi;
  logic [DW-1:0] fwd_lo;

  // Status comes only from registered count, so wr_ready has no
  // combinational path from any input.
  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign wr_ready = !full;

  assign do_enq    = wr_valid && wr_ready && !flush;
  assign do_commit = commit && !empty;
  assign rp_next   = rp + AW'(do_commit);

  // Entry payloads are not reset: count gates their visibility.
  always_ff @(posedge clk) begin
    if (do_enq) begin
      hi_mem[wp]     <= wr_hi;
      lo_mem[wp]     <= wr_lo;
      wen_hi_mem[wp] <= wr_en[LANE_HI];
      wen_lo_mem[wp] <= wr_en[LANE_LO];
    end
  end

  // Pointers, occupancy, architectural registers and the error flag.
  // A flush applies the same-cycle commit first, then collapses the queue
  // by pulling wp back to the post-commit rp.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rp    <= '0;
      wp    <= '0;
      count <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      err   <= 1'b0;
    end else begin
      if (commit && empty) begin
        err <= 1'b1;
      end
      if (do_commit) begin
        if (wen_hi_mem[rp]) hi_q <= hi_mem[rp];
        if (wen_lo_mem[rp]) lo_q <= lo_mem[rp];
      end
      rp <= rp_next;
      if (flush) begin
        wp    <= rp_next;
        count <= '0;
      end else begin
        wp    <= wp + AW'(do_enq);
        count <= count + CW'(do_enq) - CW'(do_commit);
      end
    end
  end

  hilo_fwd #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) u_fwd_hi (
    .lane_wen  (wen_hi_mem),
    .lane_data (hi_mem),
    .rp        (rp),
    .count     (count),
    .arch      (hi_q),
    .rdata     (fwd_hi)
  );

  hilo_fwd #(.DW(DW), .DEPTH(DEPTH), .CW(CW)) u_fwd_lo (
    .lane_wen  (wen_lo_mem),
    .lane_data (lo_mem),
    .rp        (rp),
    .count     (count),
    .arch      (lo_q),
    .rdata     (fwd_lo)
  );

  assign rdata = (rd_sel == RD_SEL_LO) ? fwd_lo : fwd_hi;

endmodule

// File: doc/hilo_queue.md
# hilo_queue

Parametrised HI/LO architectural register pair with a speculative write queue. Multi-cycle mul/div results and MTHI/MTLO writes enter the queue at execute. Entries retire in order into HI/LO on `commit` and are discarded on `flush` (exception or branch-miss). Reads return the youngest in-flight value per lane, so the decode/execute stage sees correct HI/LO without stalling for commit.

## Interface
- `DW`, 32: data width of HI and LO.
- `DEPTH`, 4: queue entries; a power of two, ≥2.
- `CW`, `$clog2(DEPTH+1)`: count width (derived; do not override).
- `clk` in 1: clock; all state changes on its rising edge.
- `resetn` in 1: reset, asynchronous and active-low.
- `wr_valid` in 1: enqueue request.
- `wr_ready` out 1: queue can accept; equals `!full`.
- `wr_en` in 2: lane enables; bit1 writes HI, bit0 writes LO. An entry with `wr_en==2'b00` is legal (no-op slot).
- `wr_hi` in DW: HI data for the entry.
- `wr_lo` in DW: LO data for the entry.
- `commit` in 1: retire the oldest entry.
- `flush` in 1: discard all entries not retired this cycle.
- `rd_sel` in 2: `2'b01` selects LO; any other value selects HI.
- `rdata` out DW: forwarded read of the selected lane.
- `hi_q` out DW: architectural HI (committed only).
- `lo_q` out DW: architectural LO (committed only).
- `count` out CW: number of valid entries.
- `empty` out 1: `count==0`.
- `full` out 1: `count==DEPTH`.
- `err` out 1: sticky flag, set by a commit while empty; cleared only by reset.

## Operation
- Storage is a circular buffer of DEPTH entries {wen[1:0], hi[DW], lo[DW]}.
- Read pointer `rp` and write pointer `wp` are `log2(DEPTH)` bits and wrap modulo DEPTH. Count is held explicitly.
- Enqueue occurs when `wr_valid && wr_ready && !flush`. The entry is written at `wp`, and `wp` increments.
- Commit occurs when `commit && !empty`. For the entry at `rp`, HI is updated if wen[1] and LO if wen[0]; `rp` then increments.
- `commit && empty` changes no state and sets `err`.
- Enqueue and commit in the same cycle: both take effect and count is unchanged.
  - At full, `wr_ready=0`, so the enqueue is refused even if a commit happens the same cycle.
  - Upstream must retry next cycle.
- Flush:
  - Any same-cycle commit is applied first.
  - All remaining entries are then invalidated: `wp` is set to the post-commit `rp` and count goes to 0.
  - A same-cycle enqueue is dropped.
- Forwarding: `rdata` for the selected lane is taken from the youngest valid entry whose wen bit for that lane is set. If no valid entry writes that lane, `rdata` is `hi_q`/`lo_q`.
  - The search runs over entries from `rp` to `wp-1` with wrap-around.
- `rdata`, `wr_ready`, `count`, `empty` and `full` are combinational from registered state only. `rdata` additionally depends on `rd_sel`. None depend on the same-cycle `wr_*`, `commit` or `flush`.
- Reset (asynchronous, any time, including mid-operation):
  - hi_q=0, lo_q=0.
  - Queue emptied: rp=wp=0, count=0, so empty=1, full=0, wr_ready=1.
  - err=0, rdata=0.
  - Entry payloads need not be cleared.

## Timing
- Enqueue → `rdata` forwarding: 1 cycle (visible the cycle after the accepting edge).
- Commit → `hi_q`/`lo_q`: 1 cycle. After the same edge, `rdata` still shows the committed value, because the entry is no longer in the queue and the architectural register now holds it.
- Flush → `rdata` reverts to architectural values the cycle after the flush edge.
- Throughput is one enqueue and one commit per cycle, sustained when neither full nor empty.
- No combinational path from any input to `wr_ready`.

## Structure
- Shared package `hilo_pkg` holds:
  - `RD_SEL_LO=2'b01` and `RD_SEL_HI=2'b10`.
  - Lane-index constants `LANE_HI=1` and `LANE_LO=0`.
  - Typedef `hilo_entry_t` {wen, hi, lo}, parametrised by DW via the package parameter default.
- One natural sub-module, `hilo_fwd`: combinational youngest-match priority search over DEPTH entries given rp, count and lane. It is instantiated once per lane.
- The top level holds the pointers, count, architectural registers and err.

## Test plan
- Reset with garbage inputs, then deassert: hi_q=lo_q=0, rdata=0, empty=1, wr_ready=1, err=0.
- Enqueue {wen=11, hi=0x1111, lo=0x2222}, no commit: next cycle rdata(sel=01)=0x2222, rdata(sel=10)=0x1111, hi_q=0. Commit: hi_q=0x1111, lo_q=0x2222, empty=1.
- Enqueue A {wen=10, hi=0xA}, then B {wen=01, lo=0xB}, then C {wen=10, hi=0xC}: rdata HI=0xC, LO=0xB. Commit once: hi_q=0xA while rdata HI is still 0xC.
- Fill to DEPTH=4: full=1, wr_ready=0. An extra wr_valid is ignored. Commit+enqueue alternating for 10 cycles wraps the pointers, and hi_q matches the commit order.
- Three entries queued, then flush+commit in the same cycle: the oldest retires to hi_q/lo_q, count=0, and rdata equals the new architectural values; a same-cycle enqueue is absent.
- Commit while empty: err=1 and stays set; hi_q/lo_q unchanged. Assert resetn=0 mid-queue (count=2): all outputs immediately take reset values.
